// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx serializer among NUM_REQ byte-stream
// requesters. Ownership is granted round-robin at frame boundaries and kept
// until the owner sends a byte marked last or stalls past GAP_TIMEOUT clocks.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int GAP_TIMEOUT = 2084
) (
  input  logic                   i_Clock,
  input  logic                   i_rst_n,
  input  logic [NUM_REQ-1:0]     i_Req_Valid,
  input  logic [8*NUM_REQ-1:0]   i_Req_Byte,
  input  logic [NUM_REQ-1:0]     i_Req_Last,
  output logic [NUM_REQ-1:0]     o_Req_Ready,
  output logic [NUM_REQ-1:0]     o_Grant,
  output logic                   o_Tx_DV,
  output logic [7:0]             o_Tx_Byte,
  input  logic                   i_Tx_Active,
  input  logic                   i_Tx_Done,
  output logic                   o_Timeout
);

  localparam int              IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [31:0]     GAP_LIMIT = 32'(GAP_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_DONE,
    S_GUARD
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  rr_last;
  logic [IDX_W-1:0]  gnt_idx;
  logic              last_flag;
  logic [31:0]       gap_cnt;

  logic              owner_valid;
  logic              owner_last;
  logic [7:0]        owner_byte;
  logic              any_req;
  logic [IDX_W-1:0]  next_idx;

  // uart_tx busy status is not needed: the Done pulse alone marks completion.
  logic              unused_ok;
  assign unused_ok = i_Tx_Active;

  // First requesting index searching upward from last+1, wrapping around.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [IDX_W-1:0]   last);
    logic [IDX_W-1:0] cand;
    logic             found;
    rr_pick = last;
    found   = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((int'(last) + i) % NUM_REQ);
      if (!found && req[cand]) begin
        rr_pick = cand;
        found   = 1'b1;
      end
    end
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  // Gap counter is 32 bits wide and sticks at its maximum instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    sat_inc = (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign owner_valid = |(o_Grant & i_Req_Valid);
  assign owner_last  = |(o_Grant & i_Req_Last);
  assign owner_byte  = i_Req_Byte[{gnt_idx, 3'b000} +: 8];
  assign any_req     = |i_Req_Valid;
  assign next_idx    = rr_pick(i_Req_Valid, rr_last);

  // Only the current owner can see ready, and only while a byte may be loaded.
  assign o_Req_Ready = (state == S_SEND) ? (o_Grant & i_Req_Valid) : '0;

  // Arbitration FSM with registered serializer and status outputs.
  always_ff @(posedge i_Clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= S_IDLE;
      rr_last   <= LAST_IDX;
      gnt_idx   <= '0;
      last_flag <= 1'b0;
      gap_cnt   <= '0;
      o_Grant   <= '0;
      o_Tx_DV   <= 1'b0;
      o_Tx_Byte <= '0;
      o_Timeout <= 1'b0;
    end else begin
      o_Tx_DV   <= 1'b0;
      o_Timeout <= 1'b0;
      case (state)
        S_IDLE: begin
          if (any_req) begin
            gnt_idx <= next_idx;
            rr_last <= next_idx;
            o_Grant <= onehot(next_idx);
            gap_cnt <= '0;
            state   <= S_SEND;
          end
        end
        S_SEND: begin
          if (owner_valid) begin
            // An accept on the same edge as the limit beats the timeout.
            o_Tx_Byte <= owner_byte;
            o_Tx_DV   <= 1'b1;
            last_flag <= owner_last;
            state     <= S_WAIT_DONE;
          end else if (gap_cnt >= GAP_LIMIT) begin
            o_Grant   <= '0;
            o_Timeout <= 1'b1;
            state     <= S_IDLE;
          end else begin
            gap_cnt <= sat_inc(gap_cnt);
          end
        end
        S_WAIT_DONE: begin
          if (i_Tx_Done) begin
            state <= S_GUARD;
          end
        end
        S_GUARD: begin
          // One spare cycle lets uart_tx return to idle before the next load.
          if (last_flag) begin
            o_Grant <= '0;
            state   <= S_IDLE;
          end else begin
            gap_cnt <= '0;
            state   <= S_SEND;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed bench for uart_tx_arbiter with a small
// requester driver and a fixed-latency uart_tx Done responder.
module tb_uart_tx_arbiter;

  localparam int NR       = 4;
  localparam int GT       = 16;
  localparam int DONE_LAT = 3;

  logic              clk = 1'b0;
  logic              i_rst_n;
  logic [NR-1:0]     i_Req_Valid;
  logic [8*NR-1:0]   i_Req_Byte;
  logic [NR-1:0]     i_Req_Last;
  logic [NR-1:0]     o_Req_Ready;
  logic [NR-1:0]     o_Grant;
  logic              o_Tx_DV;
  logic [7:0]        o_Tx_Byte;
  logic              i_Tx_Active;
  logic              i_Tx_Done;
  logic              o_Timeout;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(NR), .GAP_TIMEOUT(GT)) dut (
    .i_Clock     (clk),
    .i_rst_n     (i_rst_n),
    .i_Req_Valid (i_Req_Valid),
    .i_Req_Byte  (i_Req_Byte),
    .i_Req_Last  (i_Req_Last),
    .o_Req_Ready (o_Req_Ready),
    .o_Grant     (o_Grant),
    .o_Tx_DV     (o_Tx_DV),
    .o_Tx_Byte   (o_Tx_Byte),
    .i_Tx_Active (i_Tx_Active),
    .i_Tx_Done   (i_Tx_Done),
    .o_Timeout   (o_Timeout)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [8:0]  rq [NR][$];
  logic [NR-1:0] hold;
  logic [NR-1:0] arm;
  logic [7:0]  log_byte [$];
  logic [NR-1:0] log_gnt [$];
  int          dcnt;
  int          cyc;
  int          done_edge;
  int          to_cnt;
  int          proto_bad;
  logic        pending;
  logic        spur;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    logic [8:0] h;
    for (int k = 0; k < NR; k++) begin
      if (rq[k].size() > 0) begin
        h = rq[k][0];
        i_Req_Valid[k]      = !hold[k];
        i_Req_Byte[8*k +: 8] = h[7:0];
        i_Req_Last[k]       = h[8];
      end else begin
        i_Req_Valid[k] = 1'b0;
        i_Req_Last[k]  = 1'b0;
      end
    end
  endtask

  // One clock: sample at negedge, update stimulus #1 after the rising edge.
  task automatic step();
    logic [NR-1:0] hs;
    @(negedge clk);
    hs = o_Req_Ready & i_Req_Valid;
    if (((o_Req_Ready & ~o_Grant) != '0) || !$onehot0(o_Req_Ready) || !$onehot0(o_Grant))
      proto_bad++;
    if (o_Timeout) to_cnt++;
    if (o_Tx_DV) begin
      log_byte.push_back(o_Tx_Byte);
      log_gnt.push_back(o_Grant);
      if (pending || ((cyc - done_edge) < 2)) proto_bad++;
      pending = 1'b1;
      dcnt    = DONE_LAT;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (i_Tx_Done) pending = 1'b0;
    i_Tx_Done = 1'b0;
    if (dcnt > 0) begin
      dcnt--;
      if (dcnt == 0) begin
        i_Tx_Done = 1'b1;
        done_edge = cyc + 1;
      end
    end
    if (spur) begin
      i_Tx_Done = 1'b1;
      spur      = 1'b0;
      done_edge = cyc + 1;
    end
    i_Tx_Active = pending;
    for (int k = 0; k < NR; k++) begin
      if (hs[k] && rq[k].size() > 0) begin
        void'(rq[k].pop_front());
        if (arm[k]) begin
          hold[k] = 1'b1;
          arm[k]  = 1'b0;
        end
      end
    end
    drive();
  endtask

  task automatic run_until_dv(input int n, input string tag);
    int b;
    b = 0;
    while (log_byte.size() < n && b < 300) begin
      step();
      b++;
    end
    if (log_byte.size() < n) check_val({tag, "_dv_wait"}, 32'(log_byte.size()), 32'(n));
  endtask

  function automatic logic queues_empty();
    queues_empty = 1'b1;
    for (int k = 0; k < NR; k++)
      if (rq[k].size() != 0) queues_empty = 1'b0;
  endfunction

  task automatic wait_idle(input string tag);
    int b;
    b = 0;
    while (!(o_Grant == '0 && dcnt == 0 && !pending && queues_empty()) && b < 400) begin
      step();
      b++;
    end
    if (b >= 400) check_val({tag, "_idle_wait"}, 32'(o_Grant), 32'h0);
  endtask

  task automatic do_reset();
    i_rst_n     = 1'b0;
    for (int k = 0; k < NR; k++) rq[k].delete();
    hold        = '0;
    arm         = '0;
    dcnt        = 0;
    spur        = 1'b0;
    pending     = 1'b0;
    i_Tx_Done   = 1'b0;
    i_Tx_Active = 1'b0;
    done_edge   = -100;
    drive();
    repeat (2) @(posedge clk);
    #1;
    i_rst_n   = 1'b1;
    log_byte.delete();
    log_gnt.delete();
    to_cnt    = 0;
    proto_bad = 0;
  endtask

  task automatic check_log(input string tag, input int idx,
                           input logic [NR-1:0] g, input logic [7:0] b);
    check_val({tag, "_gnt"}, 32'(log_gnt[idx]), 32'(g));
    check_val({tag, "_byte"}, 32'(log_byte[idx]), 32'(b));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [NR-1:0] eg [5];
    logic [7:0]    eb [5];
    cyc         = 0;
    i_rst_n     = 1'b1;
    i_Req_Valid = '0;
    i_Req_Byte  = '0;
    i_Req_Last  = '0;
    i_Tx_Done   = 1'b0;
    i_Tx_Active = 1'b0;
    hold = '0; arm = '0; dcnt = 0; spur = 1'b0; pending = 1'b0;
    done_edge = -100; to_cnt = 0; proto_bad = 0;
    #2;
    i_rst_n = 1'b0;
    #1;
    // Reset values
    check_val("rst_grant", 32'(o_Grant), 32'h0);
    check_val("rst_dv", 32'(o_Tx_DV), 32'h0);
    check_val("rst_byte", 32'(o_Tx_Byte), 32'h0);
    check_val("rst_timeout", 32'(o_Timeout), 32'h0);
    check_val("rst_ready", 32'(o_Req_Ready), 32'h0);
    do_reset();

    // Single requester, three-byte frame
    rq[0].push_back({1'b0, 8'hA5});
    rq[0].push_back({1'b0, 8'h3C});
    rq[0].push_back({1'b1, 8'h81});
    drive();
    step();
    check_val("single_grant", 32'(o_Grant), 32'h1);
    check_val("single_dv_early", 32'(o_Tx_DV), 32'h0);
    step();
    check_val("single_dv_first", 32'(o_Tx_DV), 32'h1);
    check_val("single_byte_first", 32'(o_Tx_Byte), 32'hA5);
    run_until_dv(3, "single");
    check_val("single_grant_held", 32'(o_Grant), 32'h1);
    wait_idle("single");
    check_val("single_cnt", 32'(log_byte.size()), 32'd3);
    check_log("single0", 0, 4'b0001, 8'hA5);
    check_log("single1", 1, 4'b0001, 8'h3C);
    check_log("single2", 2, 4'b0001, 8'h81);
    check_val("single_grant_end", 32'(o_Grant), 32'h0);
    check_val("single_proto", 32'(proto_bad), 32'd0);

    // Contention: four one-byte frames plus a second frame from requester 0
    do_reset();
    rq[0].push_back({1'b1, 8'h10});
    rq[0].push_back({1'b1, 8'h14});
    rq[1].push_back({1'b1, 8'h21});
    rq[2].push_back({1'b1, 8'h32});
    rq[3].push_back({1'b1, 8'h43});
    drive();
    run_until_dv(5, "cont");
    wait_idle("cont");
    eg = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    eb = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h14};
    check_val("cont_cnt", 32'(log_byte.size()), 32'd5);
    for (int i = 0; i < 5; i++) check_log($sformatf("cont%0d", i), i, eg[i], eb[i]);
    check_val("cont_proto", 32'(proto_bad), 32'd0);

    // Frame lock: requester 2 arrives while requester 1 is mid-frame
    do_reset();
    rq[1].push_back({1'b0, 8'h51});
    rq[1].push_back({1'b0, 8'h52});
    rq[1].push_back({1'b0, 8'h53});
    rq[1].push_back({1'b1, 8'h54});
    drive();
    run_until_dv(2, "lock");
    rq[2].push_back({1'b1, 8'h60});
    drive();
    check_val("lock_grant_mid", 32'(o_Grant), 32'h2);
    run_until_dv(5, "lock");
    wait_idle("lock");
    eg = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0100};
    eb = '{8'h51, 8'h52, 8'h53, 8'h54, 8'h60};
    for (int i = 0; i < 5; i++) check_log($sformatf("lock%0d", i), i, eg[i], eb[i]);
    check_val("lock_proto", 32'(proto_bad), 32'd0);

    // Gap timeout: owner holds valid low for 16 clocks in S_SEND
    do_reset();
    rq[0].push_back({1'b0, 8'h70});
    rq[0].push_back({1'b1, 8'h71});
    rq[1].push_back({1'b1, 8'h80});
    arm[0] = 1'b1;
    drive();
    run_until_dv(1, "gap");
    repeat (4) step();
    repeat (15) step();
    check_val("gap_no_to_yet", 32'(o_Timeout), 32'h0);
    check_val("gap_grant_yet", 32'(o_Grant), 32'h1);
    step();
    check_val("gap_timeout", 32'(o_Timeout), 32'h1);
    check_val("gap_grant_clr", 32'(o_Grant), 32'h0);
    hold[0] = 1'b0;
    drive();
    step();
    check_val("gap_timeout_pulse", 32'(o_Timeout), 32'h0);
    check_val("gap_next_grant", 32'(o_Grant), 32'h2);
    run_until_dv(3, "gap");
    wait_idle("gap");
    check_val("gap_to_cnt", 32'(to_cnt), 32'd1);
    check_log("gap0", 0, 4'b0001, 8'h70);
    check_log("gap1", 1, 4'b0010, 8'h80);
    check_log("gap2", 2, 4'b0001, 8'h71);

    // Valid returns on the limit edge: accept wins, no timeout
    do_reset();
    rq[0].push_back({1'b0, 8'h90});
    rq[0].push_back({1'b1, 8'h91});
    arm[0] = 1'b1;
    drive();
    run_until_dv(1, "nogap");
    repeat (4) step();
    repeat (15) step();
    hold[0] = 1'b0;
    drive();
    step();
    check_val("nogap_dv", 32'(o_Tx_DV), 32'h1);
    check_val("nogap_byte", 32'(o_Tx_Byte), 32'h91);
    check_val("nogap_timeout", 32'(o_Timeout), 32'h0);
    wait_idle("nogap");
    check_val("nogap_to_cnt", 32'(to_cnt), 32'd0);

    // Reset asserted while waiting for Done
    do_reset();
    rq[0].push_back({1'b0, 8'hB0});
    rq[0].push_back({1'b1, 8'hB1});
    rq[3].push_back({1'b1, 8'hC3});
    drive();
    run_until_dv(1, "rstmid");
    check_val("rstmid_byte_pre", 32'(o_Tx_Byte), 32'hB0);
    i_rst_n = 1'b0;
    #1;
    check_val("rstmid_grant", 32'(o_Grant), 32'h0);
    check_val("rstmid_dv", 32'(o_Tx_DV), 32'h0);
    check_val("rstmid_byte", 32'(o_Tx_Byte), 32'h0);
    check_val("rstmid_ready", 32'(o_Req_Ready), 32'h0);
    do_reset();
    rq[3].push_back({1'b1, 8'hC3});
    rq[0].push_back({1'b1, 8'hB2});
    drive();
    run_until_dv(2, "rstmid");
    wait_idle("rstmid");
    check_log("rstmid0", 0, 4'b0001, 8'hB2);
    check_log("rstmid1", 1, 4'b1000, 8'hC3);

    // Spurious Done in S_IDLE
    do_reset();
    spur = 1'b1;
    step();
    step();
    check_val("spur_idle_grant", 32'(o_Grant), 32'h0);
    check_val("spur_idle_dv", 32'(log_byte.size()), 32'd0);
    rq[2].push_back({1'b1, 8'hE0});
    drive();
    step();
    step();
    check_val("spur_idle_then_dv", 32'(o_Tx_DV), 32'h1);
    check_val("spur_idle_then_byte", 32'(o_Tx_Byte), 32'hE0);
    wait_idle("spur_idle");

    // Spurious Done in S_SEND while the owner stalls
    do_reset();
    rq[0].push_back({1'b0, 8'hD0});
    rq[0].push_back({1'b1, 8'hD1});
    arm[0] = 1'b1;
    drive();
    run_until_dv(1, "spur_send");
    repeat (4) step();
    spur = 1'b1;
    repeat (3) step();
    check_val("spur_send_grant", 32'(o_Grant), 32'h1);
    check_val("spur_send_dv", 32'(o_Tx_DV), 32'h0);
    check_val("spur_send_cnt", 32'(log_byte.size()), 32'd1);
    hold[0] = 1'b0;
    drive();
    step();
    check_val("spur_send_resume_dv", 32'(o_Tx_DV), 32'h1);
    check_val("spur_send_resume_byte", 32'(o_Tx_Byte), 32'hD1);
    wait_idle("spur_send");
    check_val("spur_send_proto", 32'(proto_bad), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
